// File: rtl/avg_line_stepper.sv
// avg_line_stepper: vector-draw sequencer for the AVG beam path.
// Accepts one line command (start/end point) and walks the beam position
// from start to end, one pixel per accepted output beat, using integer
// Bresenham stepping.
//
// Ports:
//   clk, rst_l            clock, asynchronous active-low reset
//   start_valid/ready     line command handshake (ready only in IDLE)
//   x0, y0, x1, y1        start and end point, sampled on command accept
//   abort                 synchronous cancel of the line in progress
//   pix_valid/ready       beam position handshake
//   pix_x, pix_y          current beam position
//   pix_last              current pixel is the end point
//   busy                  line in SETUP or STEP
module avg_line_stepper #(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  input  logic             abort,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             pix_last,
  output logic             busy
);

  // Error term width: one extra bit for sign, one for the 2*err headroom.
  localparam int unsigned EW = WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_STEP  = 2'd2
  } state_t;

  state_t                r_state, w_state_n;
  logic [WIDTH-1:0]      r_cur_x, r_cur_y, w_cur_x_n, w_cur_y_n;
  logic [WIDTH-1:0]      r_end_x, r_end_y, w_end_x_n, w_end_y_n;
  logic [WIDTH-1:0]      r_dx, r_dy, w_dx_n, w_dy_n;
  logic                  r_sx_neg, r_sy_neg, w_sx_neg_n, w_sy_neg_n;
  logic signed [EW-1:0]  r_err, w_err_n;
  logic                  r_start_ready, r_pix_valid, r_pix_last, r_busy;
  logic                  w_start_ready_n, w_pix_valid_n, w_pix_last_n, w_busy_n;

  // Setup-time deltas; cur holds the start point while in SETUP.
  logic [WIDTH-1:0]      w_dx, w_dy;
  logic signed [EW-1:0]  w_err_init;
  logic signed [EW-1:0]  w_dx_s, w_dy_s, w_e2;
  logic                  w_step_x, w_step_y;
  logic [WIDTH-1:0]      w_next_x, w_next_y;

  assign w_dx = (r_end_x >= r_cur_x) ? WIDTH'(r_end_x - r_cur_x) : WIDTH'(r_cur_x - r_end_x);
  assign w_dy = (r_end_y >= r_cur_y) ? WIDTH'(r_end_y - r_cur_y) : WIDTH'(r_cur_y - r_end_y);
  assign w_err_init = $signed({2'b00, w_dx}) - $signed({2'b00, w_dy});

  // Bresenham step decision from the registered error term.
  assign w_dx_s   = $signed({2'b00, r_dx});
  assign w_dy_s   = $signed({2'b00, r_dy});
  assign w_e2     = r_err <<< 1;
  assign w_step_x = (w_e2 > -w_dy_s);
  assign w_step_y = (w_e2 < w_dx_s);
  assign w_next_x = r_sx_neg ? WIDTH'(r_cur_x - WIDTH'(1)) : WIDTH'(r_cur_x + WIDTH'(1));
  assign w_next_y = r_sy_neg ? WIDTH'(r_cur_y - WIDTH'(1)) : WIDTH'(r_cur_y + WIDTH'(1));

  // Next-state, datapath and output logic.
  always_comb begin
    w_state_n  = r_state;
    w_cur_x_n  = r_cur_x;
    w_cur_y_n  = r_cur_y;
    w_end_x_n  = r_end_x;
    w_end_y_n  = r_end_y;
    w_dx_n     = r_dx;
    w_dy_n     = r_dy;
    w_sx_neg_n = r_sx_neg;
    w_sy_neg_n = r_sy_neg;
    w_err_n    = r_err;

    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_cur_x_n = x0;
          w_cur_y_n = y0;
          w_end_x_n = x1;
          w_end_y_n = y1;
          w_state_n = S_SETUP;
        end
      end
      S_SETUP: begin
        if (abort) begin
          w_state_n = S_IDLE;
        end else begin
          w_dx_n     = w_dx;
          w_dy_n     = w_dy;
          w_sx_neg_n = (r_end_x < r_cur_x);
          w_sy_neg_n = (r_end_y < r_cur_y);
          w_err_n    = w_err_init;
          w_state_n  = S_STEP;
        end
      end
      S_STEP: begin
        // Abort wins over a simultaneous handshake; that pixel is consumed.
        if (abort) begin
          w_state_n = S_IDLE;
        end else if (pix_ready) begin
          if (r_pix_last) begin
            w_state_n = S_IDLE;
          end else begin
            w_err_n = r_err - (w_step_x ? w_dy_s : EW'(0))
                            + (w_step_y ? w_dx_s : EW'(0));
            if (w_step_x) w_cur_x_n = w_next_x;
            if (w_step_y) w_cur_y_n = w_next_y;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Outputs are registered, so derive them from the next state.
    w_start_ready_n = (w_state_n == S_IDLE);
    w_busy_n        = (w_state_n != S_IDLE);
    w_pix_valid_n   = (w_state_n == S_STEP);
    w_pix_last_n    = (w_state_n == S_STEP) &&
                      (w_cur_x_n == w_end_x_n) && (w_cur_y_n == w_end_y_n);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state       <= S_IDLE;
      r_cur_x       <= '0;
      r_cur_y       <= '0;
      r_end_x       <= '0;
      r_end_y       <= '0;
      r_dx          <= '0;
      r_dy          <= '0;
      r_sx_neg      <= 1'b0;
      r_sy_neg      <= 1'b0;
      r_err         <= '0;
      r_start_ready <= 1'b1;
      r_pix_valid   <= 1'b0;
      r_pix_last    <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_cur_x       <= w_cur_x_n;
      r_cur_y       <= w_cur_y_n;
      r_end_x       <= w_end_x_n;
      r_end_y       <= w_end_y_n;
      r_dx          <= w_dx_n;
      r_dy          <= w_dy_n;
      r_sx_neg      <= w_sx_neg_n;
      r_sy_neg      <= w_sy_neg_n;
      r_err         <= w_err_n;
      r_start_ready <= w_start_ready_n;
      r_pix_valid   <= w_pix_valid_n;
      r_pix_last    <= w_pix_last_n;
      r_busy        <= w_busy_n;
    end
  end

  assign start_ready = r_start_ready;
  assign pix_valid   = r_pix_valid;
  assign pix_last    = r_pix_last;
  assign busy        = r_busy;
  assign pix_x       = r_cur_x;
  assign pix_y       = r_cur_y;

endmodule
